key_event_ctrl: RTL

//  Sequences NUM_KEYS debounced key levels (outputs of the per-key debounce filters) into a single

---
 rtl/key_event_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
`default_nettype none
// key_event_ctrl: per-key SHORT/LONG/REPEAT classification, one pending slot per key,
// and round-robin delivery of events over a valid/ready handshake.
module key_event_ctrl #(
  parameter int NUM_KEYS    = 4,
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int CNT_W       = 26,
  parameter int KEY_W       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_level_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [KEY_W-1:0]    evt_key_o,
  output logic [1:0]          evt_type_o,
  output logic                overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

  localparam logic [1:0]       T_SHORT   = 2'b00;
  localparam logic [1:0]       T_LONG    = 2'b01;
  localparam logic [1:0]       T_REPEAT  = 2'b10;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TIME - 1);

  logic [NUM_KEYS-1:0] level_q;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] post;
  logic [1:0]          post_type [NUM_KEYS];

  logic [NUM_KEYS-1:0] slot_q;
  logic [1:0]          slot_type_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] grant;
  logic [NUM_KEYS-1:0] drop;
  logic [KEY_W-1:0]    ptr_q;
  logic [KEY_W-1:0]    gnt_idx;
  logic [KEY_W-1:0]    cand;
  logic                found;
  logic                out_free;
  logic                do_grant;

  logic                evt_valid_q;
  logic [KEY_W-1:0]    evt_key_q;
  logic [1:0]          evt_type_q;
  logic                overflow_q;

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_;

  assign press    = key_level_i & ~level_q;
  assign release_ = ~key_level_i & level_q;

  // Edge history resets to "pressed" so a key already held at reset is ignored until released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      level_q <= key_level_i;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      post[k]      = 1'b0;
      post_type[k] = T_SHORT;
      case (state_q[k])
        S_IDLE: begin
          if (press[k]) begin
            state_d[k] = S_PRESSED;
            cnt_d[k]   = '0;
          end
        end
        S_PRESSED: begin
          if (release_[k]) begin
            post[k]    = 1'b1;
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == LONG_LAST) begin
            post[k]      = 1'b1;
            post_type[k] = T_LONG;
            state_d[k]   = S_HELD;
            cnt_d[k]     = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        S_HELD: begin
          if (release_[k]) begin
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == REP_LAST) begin
            post[k]      = 1'b1;
            post_type[k] = T_REPEAT;
            cnt_d[k]     = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = S_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // Round-robin search over registered slot flags starting at the pointer.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cand = KEY_W'((int'(ptr_q) + i) % NUM_KEYS);
      if (!found && slot_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign out_free = ~evt_valid_q | evt_ready_i;
  assign do_grant = out_free & found;

  always_comb begin
    grant = '0;
    if (do_grant) grant[gnt_idx] = 1'b1;
  end

  assign drop = post & slot_q & ~grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) slot_type_q[k] <= T_SHORT;
    end else begin
      overflow_q <= |drop;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (post[k] && (!slot_q[k] || grant[k])) begin
          slot_q[k]      <= 1'b1;
          slot_type_q[k] <= post_type[k];
        end else if (grant[k]) begin
          slot_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= T_SHORT;
      ptr_q       <= '0;
    end else if (do_grant) begin
      evt_valid_q <= 1'b1;
      evt_key_q   <= gnt_idx;
      evt_type_q  <= slot_type_q[gnt_idx];
      ptr_q       <= (gnt_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_free) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_key_o   = evt_key_q;
  assign evt_type_o  = evt_type_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire
